mips_multicycle_ctrl: RTL

Multicycle control FSM for the MIPS datapath. It decodes opcode/funct, sequences fetch/decode/execute/memory/writeback, and drives the ALU `sel` code. It consumes the ALU `zero` flag for branch resolution. It is the control-side counterpart of the ALU and sits between the instruction register and the shared datapath/ALU.

---
 rtl/mips_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, write strobes and the ALU operation code.
module mips_multicycle_ctrl #(
    parameter logic [5:0] FUNCT_MUL     = 6'h18,
    parameter bit         USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e     state_q, state_d;
    logic       memDone;
    logic       functLegal;
    logic [2:0] rTypeSel;

    assign memDone = USE_MEM_READY ? mem_ready : 1'b1;
    assign state   = state_q;

    // R-type funct decode; the multiply code is a parameter so it is checked first.
    always_comb begin
        functLegal = 1'b1;
        rTypeSel   = ALU_ADD;
        if (funct == FUNCT_MUL) begin
            rTypeSel = ALU_MUL;
        end else begin
            case (funct)
                FN_ADD:  rTypeSel = ALU_ADD;
                FN_SUB:  rTypeSel = ALU_SUB;
                FN_AND:  rTypeSel = ALU_AND;
                FN_OR:   rTypeSel = ALU_OR;
                FN_SLT:  rTypeSel = ALU_SLT;
                default: functLegal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_sel    = ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_sel   = ALU_ADD;
                if (memDone) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is dispatched.
                alu_src_b = 2'b11;
                alu_sel   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (functLegal) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (memDone) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (memDone) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_sel   = rTypeSel;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // The ALU reads zero=1 while in reset, so strobes are gated off directly.
        if (!reset) begin
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            pc_write   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
